// File: rtl/aes_pkg.sv
// Shared constants and types for the AES return path (output buffer and skid entry).
package aes_pkg;

    localparam int AES_DATA_W    = 32;
    localparam int AES_BLOCK_W   = 128;
    localparam int AES_NUM_WORDS = AES_BLOCK_W / AES_DATA_W;

    typedef logic [AES_DATA_W-1:0]  aes_word_t;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic {
        OBUF_IDLE = 1'b0,
        OBUF_SEND = 1'b1
    } aes_obuf_state_e;

endpackage

// File: rtl/aes_out_skid.sv
// One-entry block register with a full flag; holds a finished block while the
// previous one is still streaming out. Push and pop are never asserted together.
module aes_out_skid
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [BLOCK_W-1:0] data_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic               full_o
);

    logic               full_q, full_d;
    logic [BLOCK_W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push_i) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/aes_output_buffer.sv
// Captures a 128-bit AES result and streams it as 32-bit words, LSW first.
// Define AES_OUT_SKID_EN to add a one-block skid entry for back-to-back results.
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter int DATA_W  = AES_DATA_W,
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_i,
    input  logic [BLOCK_W-1:0] text_i,
    input  logic               ready_i,
    output logic [DATA_W-1:0]  text_o,
    output logic               valid_o,
    output logic               last_o,
    output logic               busy_o,
    output logic               overrun_o,
    output aes_obuf_state_e    state_o
);

    localparam int NUM_WORDS = BLOCK_W / DATA_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    aes_obuf_state_e    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] hold_q, hold_d;
    logic               overrun_q, overrun_d;

    logic xfer;
    logic last_xfer;

    // Handshake: a word moves on any cycle where valid_o && ready_i; while
    // ready_i is low the presented word, last_o and the counter hold still.
    assign valid_o   = (state_q == OBUF_SEND);
    assign last_o    = valid_o && (cnt_q == LAST_CNT);
    assign xfer      = valid_o && ready_i;
    assign last_xfer = last_o && ready_i;
    assign text_o    = valid_o ? hold_q[cnt_q*DATA_W +: DATA_W] : '0;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

`ifdef AES_OUT_SKID_EN
    logic               skid_push;
    logic               skid_pop;
    logic               skid_full;
    logic [BLOCK_W-1:0] skid_data;

    aes_out_skid #(
        .BLOCK_W (BLOCK_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .data_i (text_i),
        .data_o (skid_data),
        .full_o (skid_full)
    );

    assign busy_o = skid_full && !last_xfer;
`else
    assign busy_o = valid_o && !last_xfer;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;
`ifdef AES_OUT_SKID_EN
        skid_push = 1'b0;
        skid_pop  = 1'b0;
`endif
        case (state_q)
            OBUF_IDLE: begin
                if (done_i) begin
                    hold_d  = text_i;
                    cnt_d   = '0;
                    state_d = OBUF_SEND;
                end
            end
            OBUF_SEND: begin
                if (last_xfer) begin
                    // A fresh result from the core wins over a parked one.
                    cnt_d = '0;
                    if (done_i) begin
                        hold_d = text_i;
                    end
`ifdef AES_OUT_SKID_EN
                    else if (skid_full) begin
                        hold_d   = skid_data;
                        skid_pop = 1'b1;
                    end
`endif
                    else begin
                        state_d = OBUF_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (done_i) begin
`ifdef AES_OUT_SKID_EN
                        if (!skid_full) begin
                            skid_push = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
`else
                        overrun_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = OBUF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= OBUF_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
